// File: rtl/regfile_rd16_pkg.sv
// Shared sizing and types for the 16-entry register file, its scoreboard and
// the writeback demultiplexer.
package regfile_rd16_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned NREG = 16;
    localparam int unsigned IW   = 4;

    typedef logic [IW-1:0] reg_idx_t;
    typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by claiming requests,
// cleared by writeback, with the set winning when both hit the same bit.
module regfile_scoreboard
    import regfile_rd16_pkg::*;
#(
    parameter int unsigned NREG = regfile_rd16_pkg::NREG
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     hazard
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;
    logic            busy1;
    logic            busy2;

    always_comb begin
        pending_next = pending;
        if (clr_en) pending_next[clr_idx] = 1'b0;
        if (set_en) pending_next[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    // A bit retired by this cycle's writeback is already resolved through the bypass.
    always_comb begin
        busy1  = pending[rs1] && !(clr_en && (clr_idx == rs1));
        busy2  = pending[rs2] && !(clr_en && (clr_idx == rs2));
        hazard = busy1 || busy2;
    end

endmodule

// File: rtl/regfile_rd16.sv
// Two-read, one-write register file with writeback bypass, pending-write
// interlock and a single registered operand stage with valid/ready handshake.
module regfile_rd16
    import regfile_rd16_pkg::*;
#(
    parameter int unsigned DW   = regfile_rd16_pkg::DW,
    parameter int unsigned NREG = regfile_rd16_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [3:0]    rd,
    input  logic [DW-1:0] rd_v,
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [3:0]    rs1,
    input  logic [3:0]    rs2,
    input  logic          alloc_en,
    input  logic [3:0]    alloc_rd,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] rs1_v,
    output logic [DW-1:0] rs2_v
);

    logic [DW-1:0] regs [NREG];
    logic          hazard;
    logic          accept;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (accept && alloc_en),
        .set_idx (alloc_rd),
        .clr_en  (wb_en),
        .clr_idx (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .hazard  (hazard)
    );

    always_comb begin
        iss_ready = !hazard && (!op_valid || op_ready);
        accept    = iss_valid && iss_ready;
        rd1       = (wb_en && (rd == rs1)) ? rd_v : regs[rs1];
        rd2       = (wb_en && (rd == rs2)) ? rd_v : regs[rs2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[rd] <= rd_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            rs1_v    <= '0;
            rs2_v    <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            rs1_v    <= rd1;
            rs2_v    <= rd2;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_rd16.sv
// Directed bench for regfile_rd16: writeback, bypass, interlock, back-pressure
// and asynchronous reset, each step checked against hand-computed values.
module tb_regfile_rd16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [3:0]  rd;
    logic [15:0] rd_v;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        alloc_en;
    logic [3:0]  alloc_rd;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] rs1_v;
    logic [15:0] rs2_v;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_rd16 #(
        .DW   (16),
        .NREG (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .rd        (rd),
        .rd_v      (rd_v),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .alloc_en  (alloc_en),
        .alloc_rd  (alloc_rd),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .rs1_v     (rs1_v),
        .rs2_v     (rs2_v)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ops(input string tag, input logic v, input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_op_valid"}, {31'd0, op_valid}, {31'd0, v});
        chk({tag, "_rs1_v"}, {16'd0, rs1_v}, {16'd0, a});
        chk({tag, "_rs2_v"}, {16'd0, rs2_v}, {16'd0, b});
    endtask

    task automatic rdy(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, iss_ready}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; wb_en = 1'b0; rd = '0; rd_v = '0;
        iss_valid = 1'b0; rs1 = '0; rs2 = '0;
        alloc_en = 1'b0; alloc_rd = '0; op_ready = 1'b0;
        #2;
        ops("reset", 1'b0, 16'h0000, 16'h0000);
        #10 rst_n = 1'b1;

        // basic writeback then read
        tick();
        wb_en = 1'b1; rd = 4'd5; rd_v = 16'h1234;
        tick();
        wb_en = 1'b0; iss_valid = 1'b1; rs1 = 4'd5; rs2 = 4'd0;
        rdy("basic_ready", 1'b1);
        tick();
        iss_valid = 1'b0; op_ready = 1'b1;
        ops("basic", 1'b1, 16'h1234, 16'h0000);
        tick();
        chk("drain_op_valid", {31'd0, op_valid}, 32'd0);

        // same-cycle writeback bypass
        iss_valid = 1'b1; rs1 = 4'd3; rs2 = 4'd5;
        wb_en = 1'b1; rd = 4'd3; rd_v = 16'hBEEF;
        tick();
        wb_en = 1'b0; iss_valid = 1'b0;
        ops("bypass", 1'b1, 16'hBEEF, 16'h1234);

        // claim r7, dependent request stalls until writeback
        iss_valid = 1'b1; rs1 = 4'd0; rs2 = 4'd0; alloc_en = 1'b1; alloc_rd = 4'd7;
        tick();
        alloc_en = 1'b0; rs2 = 4'd7;
        rdy("raw_stall0", 1'b0);
        tick();
        rdy("raw_stall1", 1'b0);
        tick();
        wb_en = 1'b1; rd = 4'd7; rd_v = 16'h00AA;
        rdy("raw_wb_ready", 1'b1);
        tick();
        wb_en = 1'b0;
        ops("raw_wb", 1'b1, 16'h0000, 16'h00AA);

        // back-pressure: hold for 3 cycles, then release with a waiting request
        op_ready = 1'b0; iss_valid = 1'b1; rs1 = 4'd5; rs2 = 4'd3;
        for (int i = 0; i < 3; i++) begin
            rdy("hold_ready", 1'b0);
            tick();
            ops("hold", 1'b1, 16'h0000, 16'h00AA);
        end
        op_ready = 1'b1;
        rdy("release_ready", 1'b1);
        tick();
        ops("release", 1'b1, 16'h1234, 16'hBEEF);

        // back-to-back acceptance with rs1 == rs2
        rs1 = 4'd5; rs2 = 4'd5;
        rdy("b2b_ready", 1'b1);
        tick();
        ops("same_src", 1'b1, 16'h1234, 16'h1234);

        // claim and writeback of r9 in the same cycle: claim survives
        rs1 = 4'd0; rs2 = 4'd0; alloc_en = 1'b1; alloc_rd = 4'd9;
        wb_en = 1'b1; rd = 4'd9; rd_v = 16'h0909;
        tick();
        alloc_en = 1'b0; wb_en = 1'b0; rs1 = 4'd9;
        rdy("setclr_stall0", 1'b0);
        tick();
        rdy("setclr_stall1", 1'b0);

        // writeback to non-pending r0 leaves r9 claimed
        iss_valid = 1'b0; wb_en = 1'b1; rd = 4'd0; rd_v = 16'h0F0F;
        tick();
        wb_en = 1'b0; iss_valid = 1'b1; rs1 = 4'd0; rs2 = 4'd3;
        rdy("r0_ready", 1'b1);
        tick();
        iss_valid = 1'b0;
        ops("r0_read", 1'b1, 16'h0F0F, 16'hBEEF);
        iss_valid = 1'b1; rs1 = 4'd9; rs2 = 4'd0;
        rdy("r9_still_pending", 1'b0);
        iss_valid = 1'b0;

        // claiming request reads the pre-existing value of its own destination
        wb_en = 1'b1; rd = 4'd2; rd_v = 16'h2222;
        tick();
        wb_en = 1'b0; iss_valid = 1'b1; rs1 = 4'd2; rs2 = 4'd0;
        alloc_en = 1'b1; alloc_rd = 4'd2;
        rdy("self_alloc_ready", 1'b1);
        tick();
        alloc_en = 1'b0; op_ready = 1'b0;
        ops("self_alloc", 1'b1, 16'h2222, 16'h0F0F);
        rdy("r2_pending", 1'b0);

        // asynchronous reset mid-transfer
        rst_n = 1'b0;
        #1;
        ops("async_rst", 1'b0, 16'h0000, 16'h0000);
        #2 rst_n = 1'b1;
        rs1 = 4'd2; rs2 = 4'd9;
        rdy("post_rst_ready", 1'b1);
        op_ready = 1'b1;
        tick();
        iss_valid = 1'b0;
        ops("post_rst", 1'b1, 16'h0000, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
